// File: rtl/shared_buffer_arbiter_pkg.sv
// Shared definitions for the shared buffer arbiter and its round-robin picker.
// Holds the sequencer state encoding and the default geometry constants.
package shared_buffer_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PROCESS = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the most recently served requester
//   valid - at least one request is pending
//   idx   - first set bit searching upward from last+1, wrapping around
module rr_pick #(
   parameter int NREQ = 4,
   parameter int RW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [RW-1:0]   last,
   output logic            valid,
   output logic [RW-1:0]   idx
);

   logic [NREQ-1:0] rot;
   int              j;

   // Walk offsets from farthest to nearest so the nearest hit is the one
   // left standing after the loop.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      rot   = '0;
      j     = 0;
      for (int k = NREQ; k >= 1; k--) begin
         j = int'(last) + k;
         if (j >= NREQ) j = j - NREQ;
         rot = req >> j;
         if (rot[0]) begin
            valid = 1'b1;
            idx   = RW'(j);
         end
      end
   end

endmodule

// File: rtl/shared_buffer_arbiter.sv
// Round-robin owner of the shared load/process buffer.
// A granted requester streams DEPTH words into the buffer, the processing
// engine is kicked with a one-cycle start pulse, and on its done the owner
// gets a one-cycle completion pulse before the buffer is released.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   req                - per-requester level request
//   wr_data/wr_valid   - per-requester write lanes
//   wr_ready           - per-requester accept, only the owner's bit can be set
//   grant, owner       - registered one-hot ownership and owner index
//   mem_we/addr/wdata  - buffer write port, combinational on acceptance
//   proc_start         - registered one-cycle start to the engine
//   proc_done          - engine completion
//   burst_done/abort   - registered one-cycle pulses to the owner
//   busy               - sequencer not idle
//
// state   | meaning
// IDLE    | buffer free, arbitrate among pending requests
// LOAD    | owner streams words into the buffer
// PROCESS | engine running, waiting for proc_done
// DONE    | completion pulse to owner, buffer released next cycle
module shared_buffer_arbiter
   import shared_buffer_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int NREQ  = DEF_NREQ,
   parameter int AW    = $clog2(DEPTH),
   parameter int RW    = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   input  logic [NREQ-1:0]       wr_valid,
   output logic [NREQ-1:0]       wr_ready,
   output logic [NREQ-1:0]       grant,
   output logic [RW-1:0]         owner,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   output logic                  proc_start,
   input  logic                  proc_done,
   output logic [NREQ-1:0]       burst_done,
   output logic [NREQ-1:0]       burst_abort,
   output logic                  busy
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [RW-1:0]   owner_q, owner_d;
   logic [RW-1:0]   last_q, last_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            start_q, start_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] abort_q, abort_d;

   logic            pick_valid;
   logic [RW-1:0]   pick_idx;
   logic [NREQ-1:0] owner_oh;
   logic            accept;
   logic [WIDTH-1:0] lane [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign lane[i] = wr_data[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NREQ (NREQ),
      .RW   (RW)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner_oh = NREQ'(1) << owner_q;
   assign accept   = (state_q == LOAD) && wr_valid[owner_q];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      start_d = 1'b0;
      done_d  = '0;
      abort_d = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = LOAD;
               grant_d = NREQ'(1) << pick_idx;
               owner_d = pick_idx;
               addr_d  = '0;
            end
         end
         LOAD: begin
            // The last word wins over a same-cycle request drop.
            if (accept && (addr_q == LAST_ADDR)) begin
               state_d = PROCESS;
               start_d = 1'b1;
            end else begin
               if (accept) addr_d = addr_q + AW'(1);
               if (!req[owner_q]) begin
                  state_d = IDLE;
                  abort_d = owner_oh;
                  grant_d = '0;
                  last_d  = owner_q;
               end
            end
         end
         PROCESS: begin
            // A done coinciding with the start pulse belongs to an older job.
            if (!start_q && proc_done) begin
               state_d = DONE;
               done_d  = owner_oh;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         owner_q <= '0;
         last_q  <= RW'(NREQ - 1);
         grant_q <= '0;
         start_q <= 1'b0;
         done_q  <= '0;
         abort_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         start_q <= start_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   assign wr_ready    = (state_q == LOAD) ? owner_oh : '0;
   assign mem_we      = accept;
   assign mem_addr    = accept ? addr_q : '0;
   assign mem_wdata   = accept ? lane[owner_q] : '0;
   assign grant       = grant_q;
   assign owner       = owner_q;
   assign proc_start  = start_q;
   assign burst_done  = done_q;
   assign burst_abort = abort_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/shared_buffer_arbiter.md
# shared_buffer_arbiter

Round-robin arbiter and sequencer that shares the team's DEPTH-word load/process buffer between NREQ requesters. A granted requester streams exactly DEPTH words into the buffer over a valid/ready handshake. The block then pulses the processing engine's start and waits for its done. Finally it releases the buffer and reports completion to the owner. It sits between the requester ports and the buffer/processing datapath, and replaces the per-requester start/data_in driving of that datapath.

## Interface
- WIDTH, 8: data word width
- DEPTH, 16: words per burst; must be ≥ 2
- NREQ, 4: number of requesters; must be ≥ 2
- AW, $clog2(DEPTH): buffer address width (derived)
- RW, $clog2(NREQ): owner index width (derived)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester buffer request, level
- wr_data  input  NREQ*WIDTH  per-requester write word, lane i at [i*WIDTH +: WIDTH]
- wr_valid  input  NREQ  per-requester word valid
- wr_ready  output  NREQ  per-requester word accepted; only the owner's bit can be 1
- grant  output  NREQ  one-hot ownership, registered
- owner  output  RW  index of current/last owner, registered
- mem_we  output  1  buffer write enable
- mem_addr  output  AW  buffer write address
- mem_wdata  output  WIDTH  buffer write data
- proc_start  output  1  one-cycle pulse to processing engine, registered
- proc_done  input  1  processing engine completion
- burst_done  output  NREQ  one-cycle completion pulse to owner, registered
- burst_abort  output  NREQ  one-cycle abort pulse to owner, registered
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, LOAD, PROCESS, DONE.
- **IDLE**
  - If req ≠ 0, pick the winner round-robin: the first set bit searching upward from last_owner+1, with wrap-around.
  - Next cycle: LOAD, grant = onehot(winner), owner = winner, addr = 0.
- **LOAD**
  - wr_ready[owner] = 1; all other bits are 0. This is combinational from state and owner.
  - A word is accepted when wr_valid[owner] && wr_ready[owner].
  - On acceptance: mem_we = 1, mem_addr = addr, mem_wdata = lane owner of wr_data. All three are combinational in the same cycle. addr then increments.
  - Acceptance at addr == DEPTH-1 moves to PROCESS. addr never exceeds DEPTH-1.
  - Valid from non-owners is ignored; mem_we stays 0.
  - If req[owner] drops before the last word: burst_abort[owner] pulses, grant clears, go to IDLE. proc_start is not asserted and last_owner is updated.
  - If req drop and last-word acceptance happen in the same cycle, the burst completes.
- **PROCESS**
  - proc_start = 1 on the first cycle only.
  - proc_done is sampled only while in PROCESS with proc_start low.
  - req changes are ignored here; there is no abort.
- **DONE**
  - burst_done[owner] = 1 and grant = 0.
  - last_owner = owner.
  - Next cycle: IDLE.
- proc_done outside PROCESS, or in PROCESS on the proc_start cycle, is ignored.
- After reset, last_owner = NREQ-1, so requester 0 has first priority.

## Timing
- Reset values: grant = 0, owner = 0, wr_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, proc_start = 0, burst_done = 0, burst_abort = 0, busy = 0, state = IDLE, addr = 0.
- Grant latency: req sampled in IDLE at cycle c gives grant at c+1; first write is possible at c+1.
- Full-rate burst: DEPTH writes at c+1..c+DEPTH, proc_start at c+DEPTH+1.
- proc_done at cycle u gives burst_done at u+1 and IDLE at u+2. The next grant can appear at u+3.
- Minimum arbitration cycle: DEPTH+5 cycles per burst.
- Rest-of-design reset mid-operation: everything returns to IDLE asynchronously. No pulses are emitted and the partially written buffer contents are undefined.
- Requests are never lost: req held high is eventually granted within NREQ-1 intervening bursts.

## Structure
- Package shared_buffer_arbiter_pkg holds:
  - state enum (IDLE, LOAD, PROCESS, DONE)
  - default WIDTH/DEPTH/NREQ constants
- Sub-module rr_pick is combinational:
  - inputs req[NREQ], last[RW]
  - outputs valid, idx[RW]
  - reused by other arbiters in the design.

## Test plan
- Single requester: req=0001, 16 words 0x10..0x1F → mem_addr 0..15 with matching data, proc_start at cycle 17, proc_done at 20 → burst_done=0001 at 21.
- Round-robin: req=1111 held across 4 bursts → grant order 0001, 0010, 0100, 1000, then 0001 again.
- Backpressure: owner toggles wr_valid every other cycle → exactly 16 writes, proc_start one cycle after the 16th write, no extra mem_we.
- Abort: req[2] drops after 5 words → burst_abort=0100, no proc_start; next grant goes to requester 3 if pending, else wraps.
- Non-owner noise: wr_valid=1111 during requester 1's burst → only lane-1 data written, wr_ready=0010 only.
- Async reset asserted mid-LOAD at addr 7 and mid-PROCESS → all outputs at reset values immediately; after release, req=0001 is granted first.
